// File: rtl/bit_serial_alu_ctrl_if.sv
// Handshake and result bundle between the control logic and the bit-serial ALU sequencer.
interface bit_serial_alu_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out, zero, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out, zero, ovf
    );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one result bit per clock, LSB first, start/done handshake.
// Define BIT_SERIAL_ALU_FLAGS_EN to build the zero/overflow flag logic; otherwise both flags read 0.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    bit_serial_alu_ctrl_if.slave alu
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    // One-bit slice: operand selection, full adder and logic ops.
    logic             opa, opb;
    logic             arith;
    logic             sum_bit;
    logic             add_cout;
    logic             res_bit;
    logic [WIDTH-1:0] shift_nxt;

    always_comb begin
        opa     = a_q[0];
        opb     = b_q[0];
        arith   = 1'b0;
        res_bit = 1'b0;
        unique case (op_q)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                opb   = ~b_q[0];
                arith = 1'b1;
            end
            OP_NEG: begin
                opa   = ~a_q[0];
                opb   = 1'b0;
                arith = 1'b1;
            end
            default: ;
        endcase
        sum_bit  = opa ^ opb ^ carry_q;
        add_cout = (opa & opb) | (carry_q & (opa ^ opb));
        unique case (op_q)
            OP_AND:                 res_bit = a_q[0] & b_q[0];
            OP_OR:                  res_bit = a_q[0] | b_q[0];
            OP_XOR:                 res_bit = a_q[0] ^ b_q[0];
            OP_NOT:                 res_bit = ~a_q[0];
            OP_ADD, OP_SUB, OP_NEG: res_bit = sum_bit;
            default:                res_bit = 1'b0;
        endcase
        shift_nxt = {res_bit, shift_q[WIDTH-1:1]};
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        shift_d     = shift_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (alu.start) begin
                    a_d     = alu.a;
                    b_d     = alu.b;
                    op_d    = alu.op;
                    cnt_d   = '0;
                    shift_d = '0;
                    // Subtract and negate need the +1 of two's complement.
                    carry_d = (alu.op == OP_SUB) || (alu.op == OP_NEG);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                shift_d = shift_nxt;
                carry_d = arith ? add_cout : carry_q;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d       = '0;
                    result_d    = shift_nxt;
                    carry_out_d = arith & add_cout;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
                    zero_d      = (shift_nxt == '0);
                    // carry_q is the carry into the MSB at this point.
                    ovf_d       = arith & (carry_q ^ add_cout);
`endif
                    state_d     = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            shift_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            shift_q     <= shift_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign alu.zero = zero_q;
    assign alu.ovf  = ovf_q;
`else
    assign alu.zero = 1'b0;
    assign alu.ovf  = 1'b0;
`endif

    assign alu.busy      = busy_q;
    assign alu.done      = done_q;
    assign alu.result    = result_q;
    assign alu.carry_out = carry_out_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl: directed ops push expectations, a monitor checks each done.
module tb_bit_serial_alu_ctrl;

    localparam int unsigned WIDTH = 8;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bit_serial_alu_ctrl_if #(.WIDTH(WIDTH)) alu_if ();

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (alu_if.slave)
    );

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   dones = 0;
    int   issued = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && alu_if.done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (result=%0h)", alu_if.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(alu_if.result), 32'(e.res));
                chk({e.name, "_carry"},  32'(alu_if.carry_out), 32'(e.c));
                chk({e.name, "_zero"},   32'(alu_if.zero), 32'(e.z));
                chk({e.name, "_ovf"},    32'(alu_if.ovf), 32'(e.v));
                chk({e.name, "_busy"},   32'(alu_if.busy), 32'(0));
            end
        end
    end

    // Issue one operation and measure start-to-done latency; optionally pulse start mid-RUN and in DONE.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic c, input logic z, input logic v,
                         input bit pulses);
        int n;
        sb.push_back('{nm, res, c, FLAGS & z, FLAGS & v});
        issued++;
        @(negedge clk);
        alu_if.start = 1'b1;
        alu_if.op    = op;
        alu_if.a     = a;
        alu_if.b     = b;
        @(negedge clk);
        alu_if.start = 1'b0;
        alu_if.a     = ~a;
        alu_if.b     = ~b;
        chk({nm, "_busy_run"}, 32'(alu_if.busy), 32'(1));
        n = 1;
        while (alu_if.done !== 1'b1 && n < 20) begin
            if (pulses && n == 3) begin
                alu_if.start = 1'b1;
                alu_if.op    = 3'b001;
                alu_if.a     = 8'hAA;
                alu_if.b     = 8'h55;
            end else begin
                alu_if.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(WIDTH + 1));
        if (pulses) begin
            alu_if.start = 1'b1;
            alu_if.op    = 3'b100;
            alu_if.a     = 8'h01;
            alu_if.b     = 8'h01;
            @(negedge clk);
            alu_if.start = 1'b0;
            chk({nm, "_held_result"}, 32'(alu_if.result), 32'(res));
            chk({nm, "_no_second_done"}, 32'(alu_if.done), 32'(0));
            chk({nm, "_idle_after_done"}, 32'(alu_if.busy), 32'(0));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones_before;
        rst_n        = 1'b0;
        alu_if.start = 1'b0;
        alu_if.op    = 3'b000;
        alu_if.a     = 8'h00;
        alu_if.b     = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(alu_if.busy), 32'(0));
        chk("rst_done",   32'(alu_if.done), 32'(0));
        chk("rst_result", 32'(alu_if.result), 32'(0));
        chk("rst_carry",  32'(alu_if.carry_out), 32'(0));
        chk("rst_zero",   32'(alu_if.zero), 32'(0));
        chk("rst_ovf",    32'(alu_if.ovf), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add7f01", 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("sub0507", 3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub0705", 3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("not5a",   3'b011, 8'h5A, 8'h33, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("neg00",   3'b110, 8'h00, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("op111",   3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("and",     3'b000, 8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("or",      3'b001, 8'hC3, 8'hA5, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("xor",     3'b010, 8'hC3, 8'hA5, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("addff01", 3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("sub8001", 3'b101, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("neg80",   3'b110, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("add1234_pulses", 3'b100, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort an operation with reset in its fourth RUN cycle.
        dones_before = dones;
        @(negedge clk);
        alu_if.start = 1'b1;
        alu_if.op    = 3'b100;
        alu_if.a     = 8'h7F;
        alu_if.b     = 8'h7F;
        @(negedge clk);
        alu_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   32'(alu_if.busy), 32'(0));
        chk("abort_done",   32'(alu_if.done), 32'(0));
        chk("abort_result", 32'(alu_if.result), 32'(0));
        chk("abort_carry",  32'(alu_if.carry_out), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(dones), 32'(dones_before));

        do_op("add7f01_post_rst", 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        chk("done_count", 32'(dones), 32'(issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
